// File: rtl/sha256_pkg.sv
// Shared constants for the message writer and padding generator.
// The padder also imports MAX_LEN from here.
package sha256_pkg;

  localparam int unsigned MAX_LEN = 55;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;

  localparam logic [ADDR_W-1:0] MAX_LEN_A = ADDR_W'(MAX_LEN);

  // msg_writer FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_OVF  = 3'd2;
  localparam logic [2:0] S_GO   = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

endpackage

// File: rtl/msg_writer_pad_rdy_edge.sv
// pad_rdy_edge: registers pad_rdy and flags a 0->1 transition of the registered
// value. Synchronous active-low clear.
module pad_rdy_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic pad_rdy,
  output logic pad_rise_c
);

  logic pad_q;
  logic pad_q2;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pad_q  <= 1'b0;
      pad_q2 <= 1'b0;
    end else begin
      pad_q  <= pad_rdy;
      pad_q2 <= pad_q;
    end
  end

  assign pad_rise_c = pad_q & ~pad_q2;

endmodule

// File: rtl/msg_writer.sv
// msg_writer: writes a valid/ready byte stream into message SRAM, then pulses
// main_go_sig with msg_len. Build option: MSG_WRITER_OVF_ERR_EN (discard oversize).
module msg_writer
  import sha256_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              main_go_sig,
  output logic [ADDR_W-1:0] msg_len,
  input  logic              pad_rdy,
  output logic              busy,
  output logic              err_ovf
);

  logic [2:0]        state, state_d;
  logic [ADDR_W-1:0] count, count_d, count_inc;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              go_d;
  logic [ADDR_W-1:0] msg_len_d;
  logic              busy_d;
  logic              err_d;
  logic              pad_rise_c;
  logic              xfer;

  pad_rdy_edge u_pad_rdy_edge (
    .clock      (clock),
    .reset_n    (reset_n),
    .pad_rdy    (pad_rdy),
    .pad_rise_c (pad_rise_c)
  );

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD) || (state == S_OVF);
  assign xfer      = in_valid & in_ready;
  // Counter saturates at MAX_LEN rather than wrapping
  assign count_inc = (count == MAX_LEN_A) ? count : ADDR_W'(count + ADDR_W'(1));

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    count_d     = count;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    go_d        = 1'b0;
    msg_len_d   = msg_len;
    busy_d      = busy;
    err_d       = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count;
          mem_wdata_d = in_data;
          count_d     = count_inc;
          busy_d      = 1'b1;
          if (in_last)                     state_d = S_GO;
          else if (count_inc == MAX_LEN_A) state_d = S_OVF;
          else                             state_d = S_LOAD;
        end
      end
      S_OVF: begin
        // Excess bytes are swallowed until the message ends
        if (xfer && in_last) begin
`ifdef MSG_WRITER_OVF_ERR_EN
          err_d   = 1'b1;
          busy_d  = 1'b0;
          count_d = '0;
          state_d = S_IDLE;
`else
          state_d = S_GO;
`endif
        end
      end
      S_GO: begin
        go_d      = 1'b1;
        msg_len_d = count;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (pad_rise_c) begin
          busy_d  = 1'b0;
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      count       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      main_go_sig <= 1'b0;
      msg_len     <= '0;
      busy        <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      main_go_sig <= go_d;
      msg_len     <= msg_len_d;
      busy        <= busy_d;
      err_ovf     <= err_d;
    end
  end

endmodule

// File: tb/tb_msg_writer.sv
// Directed self-checking bench for msg_writer; expectations follow the
// MSG_WRITER_OVF_ERR_EN setting of the build.
module tb_msg_writer;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       main_go_sig;
  logic [5:0] msg_len;
  logic       pad_rdy;
  logic       busy;
  logic       err_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  msg_writer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .main_go_sig (main_go_sig),
    .msg_len     (msg_len),
    .pad_rdy     (pad_rdy),
    .busy        (busy),
    .err_ovf     (err_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sends n bytes base, base+1, ...; optional idle gap before each byte.
  // With do_last, in_last accompanies the final byte and go/overflow is checked.
  task automatic send_msg(input string name, input int n, input bit gappy,
                          input logic [7:0] base, input bit do_last);
    int exp_len;
    exp_len = (n > 55) ? 55 : n;
    for (int i = 0; i < n; i++) begin
      if (gappy) begin
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (mem_we !== 1'b0) $display("FAIL %s gap_we i=%0d got %b want 0", name, i, mem_we);
        else n_pass++;
      end
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL %s in_ready i=%0d got %b want 1", name, i, in_ready);
      else n_pass++;
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      in_last  = do_last && (i == n - 1);
      tick();
      if (i < 55) begin
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'(i) || mem_wdata !== 8'(base + i))
          $display("FAIL %s write i=%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                   name, i, mem_we, mem_addr, mem_wdata, i, 8'(base + i));
        else n_pass++;
      end else begin
        n_checks++;
        if (mem_we !== 1'b0) $display("FAIL %s discard_we i=%0d got %b want 0", name, i, mem_we);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!do_last) return;
`ifdef MSG_WRITER_OVF_ERR_EN
    if (n > 55) begin
      n_checks++;
      if (err_ovf !== 1'b1 || busy !== 1'b0)
        $display("FAIL %s err_pulse got err=%b busy=%b want err=1 busy=0", name, err_ovf, busy);
      else n_pass++;
      tick();
      n_checks++;
      if (err_ovf !== 1'b0 || main_go_sig !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL %s after_err got err=%b go=%b rdy=%b want 0 0 1", name, err_ovf, main_go_sig, in_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (main_go_sig !== 1'b0) $display("FAIL %s no_go got %b want 0", name, main_go_sig);
      else n_pass++;
      return;
    end
`endif
    n_checks++;
    if (main_go_sig !== 1'b0 || in_ready !== 1'b0 || err_ovf !== 1'b0 || busy !== 1'b1)
      $display("FAIL %s pre_go got go=%b rdy=%b err=%b busy=%b want 0 0 0 1",
               name, main_go_sig, in_ready, err_ovf, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (main_go_sig !== 1'b1 || msg_len !== 6'(exp_len))
      $display("FAIL %s go got go=%b len=%0d want go=1 len=%0d", name, main_go_sig, msg_len, exp_len);
    else n_pass++;
    tick();
    n_checks++;
    if (main_go_sig !== 1'b0 || msg_len !== 6'(exp_len) || in_ready !== 1'b0)
      $display("FAIL %s post_go got go=%b len=%0d rdy=%b want 0 %0d 0",
               name, main_go_sig, msg_len, in_ready, exp_len);
    else n_pass++;
  endtask

  // pad_rdy 0->1: busy drops two edges later, then pad_rdy returns low
  task automatic release_pad(input string name);
    pad_rdy = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL %s rel_early busy got %b want 1", name, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s released got busy=%b rdy=%b want 0 1", name, busy, in_ready);
    else n_pass++;
    pad_rdy = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    pad_rdy  = 1'b0;
    tick();
    tick();
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 8'd0 || main_go_sig !== 1'b0 ||
        msg_len !== 6'd0 || busy !== 1'b0 || err_ovf !== 1'b0)
      $display("FAIL reset got we=%b addr=%0d wd=%h go=%b len=%0d busy=%b err=%b want all 0",
               mem_we, mem_addr, mem_wdata, main_go_sig, msg_len, busy, err_ovf);
    else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_abc();
    send_msg("abc", 3, 1'b0, 8'h61, 1'b1);
    tick();
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL abc hold got busy=%b rdy=%b want 1 0", busy, in_ready);
    else n_pass++;
    release_pad("abc");
  endtask

  task automatic test_full55();
    send_msg("full55", 55, 1'b0, 8'h00, 1'b1);
    release_pad("full55");
  endtask

  task automatic test_oversize();
    send_msg("ovf60", 60, 1'b0, 8'h10, 1'b1);
`ifndef MSG_WRITER_OVF_ERR_EN
    release_pad("ovf60");
`endif
  endtask

  task automatic test_gappy();
    send_msg("gappy", 3, 1'b1, 8'h61, 1'b1);
    release_pad("gappy");
  endtask

  task automatic test_stale_pad();
    pad_rdy = 1'b1;
    tick();
    tick();
    send_msg("stale", 3, 1'b0, 8'h41, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0)
        $display("FAIL stale blocked i=%0d got busy=%b rdy=%b we=%b want 1 0 0", i, busy, in_ready, mem_we);
      else n_pass++;
    end
    in_valid = 1'b0;
    pad_rdy  = 1'b0;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) $display("FAIL stale low busy got %b want 1", busy);
    else n_pass++;
    release_pad("stale");
  endtask

  task automatic test_reset_mid();
    send_msg("mid", 10, 1'b0, 8'h20, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 8'd0 || main_go_sig !== 1'b0 ||
        msg_len !== 6'd0 || busy !== 1'b0 || err_ovf !== 1'b0)
      $display("FAIL mid_reset got we=%b addr=%0d wd=%h go=%b len=%0d busy=%b err=%b want all 0",
               mem_we, mem_addr, mem_wdata, main_go_sig, msg_len, busy, err_ovf);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (main_go_sig !== 1'b0) $display("FAIL mid_no_go i=%0d got %b want 0", i, main_go_sig);
      else n_pass++;
    end
    send_msg("after_rst", 3, 1'b0, 8'h61, 1'b1);
    release_pad("after_rst");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_full55();
    test_oversize();
    test_gappy();
    test_stale_pad();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
